// File: rtl/adc_fsync_rx_mc.sv
`timescale 1ns/1ps
// adc_fsync_rx_mc
// Frame-sync serial ADC receiver for daisy-chained converters. Oversamples the
// sck/dout/fsync pins in the clk domain, deserialises each frame into CH words
// of DW data + SW status bits, buffers them and emits them on an AXI4-Stream
// master. Also drives the delayed ADC start pin and reports overflow, framing
// errors and clipping.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   en                  capture enable (also gates the start delay counter)
//   sck, dout, fsync    asynchronous ADC pins
//   start               ADC START pin
//   m_axis_*            stream out; tuser = {status, channel index}
//   overflow, frame_err sticky error flags
//   drop_cnt            saturating count of words dropped on a full FIFO
//   clip                top two bits of the current tdata differ
module adc_fsync_rx_mc #(
  parameter int CH          = 4,
  parameter int DW          = 24,
  parameter int SW          = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int LAST_FRAMES = 10240,
  parameter int START_DLY   = 300,
  parameter int SYNC_STG    = 2,
  localparam int CW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sck,
  input  logic             dout,
  input  logic             fsync,
  output logic             start,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DW-1:0]    m_axis_tdata,
  output logic [SW+CW-1:0] m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             overflow,
  output logic             frame_err,
  output logic [15:0]      drop_cnt,
  output logic             clip
);
  localparam int UW  = SW + CW;
  localparam int WW  = DW + SW;
  localparam int EW  = 1 + UW + DW;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(WW + 1);
  localparam int FW  = (LAST_FRAMES > 1) ? $clog2(LAST_FRAMES) : 1;
  localparam int SDW = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;

  // ---- start delay ----
  logic [SDW-1:0] start_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n)                                       start_cnt <= '0;
    else if (en && start_cnt != SDW'(START_DLY))      start_cnt <= start_cnt + 1'b1;
  end
  assign start = (start_cnt == SDW'(START_DLY));

  // ---- pin synchronisers: equal depth keeps the three pins aligned; the
  // extra top flop on sck/fsync is the previous value for edge detection ----
  logic [SYNC_STG:0]   sck_p, fs_p;
  logic [SYNC_STG-1:0] dout_p;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_p <= '0; fs_p <= '0; dout_p <= '0;
    end else begin
      sck_p  <= {sck_p[SYNC_STG-1:0], sck};
      fs_p   <= {fs_p[SYNC_STG-1:0], fsync};
      dout_p <= {dout_p[SYNC_STG-2+1-1:0], dout} >> 0;
    end
  end
  logic sck_rise, fs_rise, dout_s;
  assign sck_rise = sck_p[SYNC_STG-1] & ~sck_p[SYNC_STG];
  assign fs_rise  = fs_p[SYNC_STG-1]  & ~fs_p[SYNC_STG];
  assign dout_s   = dout_p[SYNC_STG-1];

  // ---- frame FSM ----
  typedef enum logic {IDLE, CAPTURE} state_t;
  state_t state_q, state_d;

  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] ch_cnt;
  logic [FW-1:0] frame_cnt;
  logic [WW-2:0] sr;
  logic [WW-1:0] sr_nxt;
  logic          bit_last, ch_last, push;

  assign sr_nxt   = {sr, dout_s};
  assign bit_last = (bit_cnt == BW'(WW - 1));
  assign ch_last  = (ch_cnt == CW'(CH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    // fsync wins over a coincident sck rise: the frame restarts
    if (fs_rise) begin
      state_d = CAPTURE;
    end else if (state_q == CAPTURE && sck_rise && bit_last) begin
      push = 1'b1;
      if (ch_last) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0; ch_cnt <= '0; frame_cnt <= '0; sr <= '0; frame_err <= 1'b0;
    end else if (fs_rise) begin
      bit_cnt <= '0;
      ch_cnt  <= '0;
      if (state_q == CAPTURE) frame_err <= 1'b1;
    end else if (state_q == CAPTURE && sck_rise) begin
      sr <= sr_nxt[WW-2:0];
      if (bit_last) begin
        bit_cnt <= '0;
        ch_cnt  <= ch_last ? '0 : ch_cnt + 1'b1;
        // frame counter frozen while capture is disabled
        if (ch_last && en)
          frame_cnt <= (frame_cnt == FW'(LAST_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // ---- word assembly ----
  logic [UW-1:0] push_user;
  logic [EW-1:0] push_entry;
  generate
    if (SW > 0) begin : g_status
      assign push_user = {sr_nxt[SW-1:0], ch_cnt};
    end else begin : g_nostatus
      assign push_user = ch_cnt;
    end
  endgenerate
  assign push_entry = {ch_last && frame_cnt == FW'(LAST_FRAMES - 1), push_user, sr_nxt[WW-1:SW]};

  // ---- output FIFO: the output register counts as one entry, so total
  // occupancy (cnt + tvalid) never exceeds FIFO_DEPTH ----
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, occ;
  logic          pop, load, full, acc, drop, bypass, wr, rd;

  assign pop    = m_axis_tvalid & m_axis_tready;
  assign load   = ~m_axis_tvalid | pop;
  assign occ    = cnt + (AW+1)'(m_axis_tvalid);
  assign full   = (occ == (AW+1)'(FIFO_DEPTH));
  assign acc    = push & en & (~full | pop);
  assign drop   = push & en & full & ~pop;
  assign bypass = acc & load & (cnt == '0);
  assign wr     = acc & ~bypass;
  assign rd     = load & (cnt != '0);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; cnt <= '0;
      m_axis_tvalid <= 1'b0; m_axis_tdata <= '0; m_axis_tuser <= '0; m_axis_tlast <= 1'b0;
      overflow <= 1'b0; drop_cnt <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
      if (rd) begin
        {m_axis_tlast, m_axis_tuser, m_axis_tdata} <= mem[rd_ptr];
        m_axis_tvalid <= 1'b1;
      end else if (bypass) begin
        {m_axis_tlast, m_axis_tuser, m_axis_tdata} <= push_entry;
        m_axis_tvalid <= 1'b1;
      end else if (pop) begin
        m_axis_tvalid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign clip = m_axis_tdata[DW-1] ^ m_axis_tdata[DW-2];
endmodule

// File: tb/tb_adc_fsync_rx_mc.sv
`timescale 1ns/1ps
module tb_adc_fsync_rx_mc;
  localparam int CH = 4, DW = 24, SW = 8, UW = 10, DEPTH = 16, LF = 3;

  logic clk = 0, rst_n = 0, en = 0, sck = 0, dout = 0, fsync = 0, m_axis_tready = 0;
  logic start, m_axis_tvalid, m_axis_tlast, overflow, frame_err, clip;
  logic [DW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic [15:0]   drop_cnt;

  adc_fsync_rx_mc #(.CH(CH), .DW(DW), .SW(SW), .FIFO_DEPTH(DEPTH), .LAST_FRAMES(LF),
                    .START_DLY(300), .SYNC_STG(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sck(sck), .dout(dout), .fsync(fsync),
    .start(start), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .overflow(overflow), .frame_err(frame_err), .drop_cnt(drop_cnt), .clip(clip));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  typedef struct packed { logic [DW-1:0] d; logic [UW-1:0] u; logic l; logic c; } beat_t;
  beat_t exp_q[$], obs_q[$];
  int m_frame = 0, m_occ = 0, m_drops = 0;

  // collect every accepted beat
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      obs_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast, clip});
      if (m_occ > 0) m_occ--;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // reference: a completed word either lands in the buffer, is dropped when
  // the buffer holds DEPTH words, or vanishes when capture is disabled
  task automatic model_push(input logic [31:0] w, input int ch);
    beat_t b;
    if (!en) return;
    if (m_occ < DEPTH) begin
      b.d = w[31:8]; b.u = {w[7:0], 2'(ch)}; b.l = (ch == CH-1 && m_frame == LF-1);
      b.c = w[31] ^ w[30];
      exp_q.push_back(b); m_occ++;
    end else if (m_drops < 65535) m_drops++;
  endtask

  task automatic send_frame(input logic [3:0][31:0] w, input int nbits);
    fsync = 1; tick(3); fsync = 0; tick(3);
    for (int b = 0; b < nbits; b++) begin
      dout = w[b/32][31-(b%32)];
      sck = 0; tick(3); sck = 1; tick(3);
      if (b % 32 == 31) model_push(w[b/32], b/32);
    end
    sck = 0; tick(3);
    if (nbits == 128 && en) m_frame = (m_frame + 1) % LF;
  endtask

  function automatic logic [3:0][31:0] rand_frame();
    logic [3:0][31:0] w;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    return w;
  endfunction

  task automatic drain();
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 3000) begin tick(1); t++; end
    n_cmp++;
    if (t >= 3000) begin
      n_bad++;
      $display("FAIL drain_timeout got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    tick(10);
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; tick(5);
    @(negedge clk);
    n_cmp++;
    if ({start, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, overflow, frame_err, drop_cnt, clip} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got v=%b d=%h u=%h l=%b ov=%b fe=%b dc=%0d clip=%b start=%b want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, overflow, frame_err, drop_cnt, clip, start);
    end
    tick(1); rst_n = 1; tick(1);
  endtask

  task automatic test_start();
    en = 1; tick(150); en = 0; tick(200);
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL start_frozen got %b want 0", start); end
    en = 1; tick(149);
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL start_299 got %b want 0", start); end
    tick(1);
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL start_300 got %b want 1", start); end
    en = 0; tick(20);
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL start_hold got %b want 1", start); end
    en = 1;
  endtask

  task automatic test_basic();
    m_axis_tready = 1;
    send_frame({32'h123456FF, 32'h00000100, 32'h8000005A, 32'h7FFFFFA5}, 128);
    drain();
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_tlast();
    int nl = 0;
    for (int f = 0; f < 5; f++) send_frame(rand_frame(), 128);
    drain();
    foreach (obs_q[i]) if (obs_q[i].l) nl++;
    n_cmp++; if (nl !== 2) begin n_bad++; $display("FAIL tlast_count got %0d want 2", nl); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL tlast_count_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL tlast_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_en_gate();
    en = 0;
    send_frame(rand_frame(), 128);
    tick(20);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL en_gate got %0d beats want 0", obs_q.size()); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL en_gate_drop got %0d want 0", drop_cnt); end
    obs_q.delete(); exp_q.delete();
    en = 1;
  endtask

  task automatic test_back_to_back();
    bit done = 0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(rand_frame(), 128);
        done = 1;
      end
      begin
        beat_t pb; bit pv = 0; beat_t cur;
        while (!done) begin
          @(negedge clk);
          cur = {m_axis_tdata, m_axis_tuser, m_axis_tlast, clip};
          if (pv) begin
            n_cmp++;
            if ({m_axis_tvalid, cur} !== {1'b1, pb}) begin
              n_bad++; $display("FAIL hold_stable got v=%b %h want v=1 %h", m_axis_tvalid, cur, pb);
            end
          end
          pv = m_axis_tvalid && !m_axis_tready; pb = cur;
          @(posedge clk); #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_tready = 1;
    drain();
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    m_axis_tready = 0;
    for (int f = 0; f < 6; f++) send_frame(rand_frame(), 128);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (drop_cnt !== 16'(m_drops) || m_drops != 8) begin n_bad++; $display("FAIL ovf_drop_cnt got %0d want %0d (model %0d)", drop_cnt, 8, m_drops); end
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got %b want 1", m_axis_tvalid); end
    m_axis_tready = 1;
    drain();
    n_cmp++; if (obs_q.size() !== 16) begin n_bad++; $display("FAIL ovf_count got %0d want 16", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_frame();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short_pre got %b want 0", frame_err); end
    send_frame(rand_frame(), 40);
    send_frame(rand_frame(), 128);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short_err got %b want 1", frame_err); end
    drain();
    n_cmp++; if (obs_q.size() !== 5) begin n_bad++; $display("FAIL short_count got %0d want 5", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL short_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 0;
    send_frame(rand_frame(), 128);
    send_frame(rand_frame(), 40);
    rst_n = 0; tick(1);
    n_cmp++;
    if ({m_axis_tvalid, drop_cnt, overflow, frame_err} !== '0) begin
      n_bad++; $display("FAIL mid_reset got v=%b dc=%0d ov=%b fe=%b want 0", m_axis_tvalid, drop_cnt, overflow, frame_err);
    end
    obs_q.delete(); exp_q.delete(); m_occ = 0; m_frame = 0; m_drops = 0;
    rst_n = 1; tick(2); m_axis_tready = 1;
    send_frame(rand_frame(), 128);
    drain();
    n_cmp++; if (obs_q.size() !== 4) begin n_bad++; $display("FAIL mid_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mid_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_start();
    test_basic();
    test_tlast();
    test_en_gate();
    test_back_to_back();
    test_overflow();
    test_short_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
